pipelined_barrel_shifter: RTL

//   Parametrised, pipelined barrel shifter.
//   - Shift amount and mode are chosen per transaction, not fixed at elaboration time.
//   - Modes: logical left, logical right, arithmetic right, optional rotate right.
//   - One log-stage per shift-amount bit, each stage registered.
//   - valid/ready handshake with full backpressure; sits between datapath producers and consumers.
//

---
 rtl/shift_pkg.sv | 15 +
 rtl/barrel_shift_stage.sv | 95 +++++++++
 rtl/pipelined_barrel_shifter.sv | 81 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Purpose : shared shift-mode encoding for the pipelined barrel shifter.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
package shift_pkg;

    localparam int SHIFT_MODE_W = 2;

    typedef enum logic [SHIFT_MODE_W-1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_mode_t;

endpackage

// File: rtl/barrel_shift_stage.sv
// Purpose : one log-stage of the barrel shifter; shifts by DIST when the matching amt bit is set, then registers.
// Latency : 1 cycle.
// Backpressure : in_ready = register empty or being drained downstream; stage holds its contents otherwise.
//
// Ports: clk/rst (async active-high); in_valid/in_ready/in_data/in_amt/in_mode from the previous stage;
//        out_valid/out_ready/out_data/out_amt/out_mode to the next stage.
// Config: PIPELINED_BARREL_SHIFTER_ROTATE_EN builds the rotate path; without it mode 11 behaves as LSR.
module barrel_shift_stage
    import shift_pkg::*;
#(
    parameter int W    = 8,
    parameter int DIST = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    input  logic [$clog2(W)-1:0]    in_amt,
    input  logic [SHIFT_MODE_W-1:0] in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_data,
    output logic [$clog2(W)-1:0]    out_amt,
    output logic [SHIFT_MODE_W-1:0] out_mode
);

    localparam int SW = $clog2(W);
    // Amount bit that this stage consumes.
    localparam int K  = $clog2(DIST);

    logic [W-1:0]            shifted;
    logic                    advance;
    logic                    valid_q, valid_d;
    logic [W-1:0]            data_q,  data_d;
    logic [SW-1:0]           amt_q,   amt_d;
    logic [SHIFT_MODE_W-1:0] mode_q,  mode_d;

    always_comb begin
        shifted = in_data;
        if (in_amt[K]) begin
            case (shift_mode_t'(in_mode))
                SHIFT_LSL: shifted = in_data << DIST;
                SHIFT_LSR: shifted = in_data >> DIST;
                // Operand top bit is still the original sign: every earlier ASR stage replicated it.
                SHIFT_ASR: shifted = $signed(in_data) >>> DIST;
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
                SHIFT_ROR: shifted = (in_data >> DIST) | (in_data << (W - DIST));
`else
                SHIFT_ROR: shifted = in_data >> DIST;
`endif
                default:   shifted = in_data;
            endcase
        end
    end

    // Stage may load when empty or when its current item leaves this cycle.
    assign advance  = !valid_q || out_ready;
    assign in_ready = advance;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        amt_d   = amt_q;
        mode_d  = mode_q;
        if (advance) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = shifted;
                amt_d  = in_amt;
                mode_d = in_mode;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_amt   = amt_q;
    assign out_mode  = mode_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Purpose : per-transaction LSL/LSR/ASR/ROR barrel shifter, one registered stage per amount bit.
// Latency : SW cycles from input transfer to down_valid; 1 item/cycle throughput.
// Backpressure : full valid/ready chain; a stalled output freezes the pipe, up_ready drops once it is full.
//
// Ports: clk, rst (async active-high); up_valid/up_ready/up_data/up_amt/up_mode (input side);
//        down_valid/down_ready/down_data (output side).
// Config: define PIPELINED_BARREL_SHIFTER_ROTATE_EN for rotate-right on mode 11; otherwise mode 11 acts as LSR.
module pipelined_barrel_shifter
    import shift_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic [W-1:0]            up_data,
    input  logic [SW-1:0]           up_amt,
    input  logic [SHIFT_MODE_W-1:0] up_mode,
    output logic                    down_valid,
    input  logic                    down_ready,
    output logic [W-1:0]            down_data
);

    // Holds off acceptance for the first cycle after reset release.
    logic init_q, init_d;

    logic [SW:0]             vld;
    logic [SW:0]             rdy;
    logic [W-1:0]            dat  [SW+1];
    logic [SW-1:0]           amt  [SW+1];
    logic [SHIFT_MODE_W-1:0] mode [SW+1];
    logic                    unused_tail;

    always_comb begin
        init_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q <= 1'b0;
        end else begin
            init_q <= init_d;
        end
    end

    assign vld[0]   = up_valid && init_q;
    assign dat[0]   = up_data;
    assign amt[0]   = up_amt;
    assign mode[0]  = up_mode;
    assign up_ready = rdy[0] && init_q;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        barrel_shift_stage #(
            .W    (W),
            .DIST (1 << k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld[k]),
            .in_ready  (rdy[k]),
            .in_data   (dat[k]),
            .in_amt    (amt[k]),
            .in_mode   (mode[k]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .out_data  (dat[k+1]),
            .out_amt   (amt[k+1]),
            .out_mode  (mode[k+1])
        );
    end

    assign rdy[SW]    = down_ready;
    assign down_valid = vld[SW];
    assign down_data  = dat[SW];

    // Amount and mode are fully consumed once the last stage has shifted.
    assign unused_tail = ^{amt[SW], mode[SW]};

endmodule
